// File: rtl/qed_consistency_checker_pkg.sv
// qed_pkg: shared constants and encodings for the QED commit-side consistency checker.
package qed_pkg;

    localparam int unsigned QED_NUM_PAIRS  = 16;
    localparam int unsigned QED_DUP_OFFSET = 16;

    // Last pair index visited by a sweep (pair 0 is never compared).
    localparam logic [3:0] QED_LAST_PAIR = 4'(QED_NUM_PAIRS - 1);

    typedef enum logic [1:0] {
        QED_FAIL_MISMATCH = 2'd0,
        QED_FAIL_ORDER    = 2'd1,
        QED_FAIL_RANGE    = 2'd2,
        QED_FAIL_OVERFLOW = 2'd3
    } qed_fail_e;

    typedef enum logic [1:0] {
        QED_TRACK = 2'd0,
        QED_CHECK = 2'd1,
        QED_FAIL  = 2'd2
    } qed_state_e;

endpackage

// File: rtl/qed_consistency_checker_if.sv
// Commit stream in, check status out, for the QED consistency checker.
interface qed_consistency_checker_if;
    import qed_pkg::*;

    logic        commit_valid;
    logic        commit_dup;
    logic        commit_we;
    logic [4:0]  commit_rd;
    logic [31:0] commit_data;

    logic        qed_ready;
    logic        qed_check_pass;
    logic        qed_check_fail;
    logic [1:0]  fail_code;
    logic [3:0]  fail_reg;
    logic [15:0] checks_done;

    modport master (
        output commit_valid, commit_dup, commit_we, commit_rd, commit_data,
        input  qed_ready, qed_check_pass, qed_check_fail, fail_code, fail_reg, checks_done
    );

    modport slave (
        input  commit_valid, commit_dup, commit_we, commit_rd, commit_data,
        output qed_ready, qed_check_pass, qed_check_fail, fail_code, fail_reg, checks_done
    );

endinterface

// File: rtl/qed_consistency_checker_shadow_rf.sv
// qed_shadow_rf: 32x32 shadow of the architectural register file, one write
// port, two combinational read ports returning pair (rN, rN+16).
module qed_shadow_rf
    import qed_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  pair_i,
    output logic [31:0] orig_o,
    output logic [31:0] dup_o
);

    logic [31:0] regs_q [32];

    // Mirror committed writes; r0 is never written so it reads as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign orig_o = regs_q[{1'b0, pair_i}];
    assign dup_o  = regs_q[5'(pair_i) + 5'(QED_DUP_OFFSET)];

endmodule

// File: rtl/qed_consistency_checker.sv
// qed_consistency_checker: tracks original/duplicate commit balance, sweeps
// register pairs (rN, rN+16) when balanced, reports pass or sticky failure.
module qed_consistency_checker
    import qed_pkg::*;
#(
    parameter int unsigned DIFF_W = 8
) (
    input logic                      clk,
    input logic                      reset,
    qed_consistency_checker_if.slave bus
);

    qed_state_e        state_q, state_d;
    logic [DIFF_W-1:0] diff_q, diff_d;
    logic              pending_q, pending_d;
    logic [3:0]        idx_q, idx_d;
    logic              ready_q, ready_d;
    logic              pass_q, pass_d;
    logic              fail_q, fail_d;
    logic [1:0]        code_q, code_d;
    logic [3:0]        freg_q, freg_d;
    logic [15:0]       checks_q, checks_d;

    logic              rd_nz;
    logic              order_err, range_err, ovf_err, commit_err;
    qed_fail_e         commit_code;
    logic [DIFF_W-1:0] diff_step;
    logic              sh_we;
    logic [31:0]       sh_orig, sh_dup;

    assign rd_nz     = |bus.commit_rd;
    assign order_err = bus.commit_valid & bus.commit_dup & (diff_q == '0);
    assign ovf_err   = bus.commit_valid & ~bus.commit_dup & (diff_q == '1);
    assign range_err = bus.commit_valid & bus.commit_we &
                       (bus.commit_dup ? (rd_nz & ~bus.commit_rd[4]) : bus.commit_rd[4]);
    assign commit_err  = order_err | range_err | ovf_err;
    assign commit_code = order_err ? QED_FAIL_ORDER :
                         range_err ? QED_FAIL_RANGE : QED_FAIL_OVERFLOW;
    assign diff_step   = bus.commit_dup ? (diff_q - DIFF_W'(1)) : (diff_q + DIFF_W'(1));
    assign sh_we       = (state_q != QED_FAIL) & bus.commit_valid & bus.commit_we;

    qed_shadow_rf u_shadow (
        .clk     (clk),
        .rst_n   (reset),
        .we_i    (sh_we),
        .waddr_i (bus.commit_rd),
        .wdata_i (bus.commit_data),
        .pair_i  (idx_q),
        .orig_o  (sh_orig),
        .dup_o   (sh_dup)
    );

    // Next-state: a commit always wins over the sweep (error, or abort to TRACK).
    always_comb begin
        state_d   = state_q;
        diff_d    = diff_q;
        pending_d = pending_q;
        idx_d     = idx_q;
        ready_d   = 1'b0;
        pass_d    = 1'b0;
        fail_d    = fail_q;
        code_d    = code_q;
        freg_d    = freg_q;
        checks_d  = checks_q;
        unique case (state_q)
            QED_TRACK, QED_CHECK: begin
                if (commit_err) begin
                    state_d = QED_FAIL;
                    fail_d  = 1'b1;
                    code_d  = commit_code;
                    freg_d  = '0;
                end else if (bus.commit_valid) begin
                    state_d   = QED_TRACK;
                    diff_d    = diff_step;
                    pending_d = 1'b1;
                end else if (state_q == QED_TRACK) begin
                    if ((diff_q == '0) && pending_q) begin
                        state_d   = QED_CHECK;
                        ready_d   = 1'b1;
                        pending_d = 1'b0;
                        idx_d     = 4'd1;
                    end
                end else if (sh_orig != sh_dup) begin
                    state_d = QED_FAIL;
                    fail_d  = 1'b1;
                    code_d  = QED_FAIL_MISMATCH;
                    freg_d  = idx_q;
                end else if (idx_q == QED_LAST_PAIR) begin
                    state_d  = QED_TRACK;
                    pass_d   = 1'b1;
                    checks_d = checks_q + 16'd1;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            QED_FAIL: begin
                state_d = QED_FAIL;
            end
            default: begin
                state_d = QED_TRACK;
            end
        endcase
    end

    // FSM, counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= QED_TRACK;
            diff_q    <= '0;
            pending_q <= 1'b0;
            idx_q     <= '0;
            ready_q   <= 1'b0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            code_q    <= '0;
            freg_q    <= '0;
            checks_q  <= '0;
        end else begin
            state_q   <= state_d;
            diff_q    <= diff_d;
            pending_q <= pending_d;
            idx_q     <= idx_d;
            ready_q   <= ready_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            code_q    <= code_d;
            freg_q    <= freg_d;
            checks_q  <= checks_d;
        end
    end

    assign bus.qed_ready      = ready_q;
    assign bus.qed_check_pass = pass_q;
    assign bus.qed_check_fail = fail_q;
    assign bus.fail_code      = code_q;
    assign bus.fail_reg       = freg_q;
    assign bus.checks_done    = checks_q;

endmodule

// File: tb/tb_qed_consistency_checker.sv
// Table-driven bench for qed_consistency_checker: one DUT with DIFF_W=8 for
// the main scenarios, one with DIFF_W=2 for counter overflow and reset recovery.
module tb_qed_consistency_checker;
    import qed_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_a = 1'b0;
    logic reset_b = 1'b0;

    qed_consistency_checker_if bus_a ();
    qed_consistency_checker_if bus_b ();

    qed_consistency_checker #(.DIFF_W(8)) dut_a (.clk(clk), .reset(reset_a), .bus(bus_a));
    qed_consistency_checker #(.DIFF_W(2)) dut_b (.clk(clk), .reset(reset_b), .bus(bus_b));

    typedef struct packed {
        logic        ready;
        logic        pass;
        logic        fail;
        logic [1:0]  code;
        logic [3:0]  freg;
        logic [15:0] checks;
    } obs_t;

    typedef struct {
        bit          dut;
        bit          rst;
        logic        v;
        logic        dup;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        obs_t        exp;
        string       tag;
    } vec_t;

    localparam obs_t Z = '0;

    vec_t        tbl[$];
    obs_t        sb[$];
    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    string       section = "";

    function automatic obs_t e(input logic rdy, input logic pass, input logic fail,
                               input logic [1:0] code, input logic [3:0] freg,
                               input logic [15:0] k);
        obs_t r;
        r.ready = rdy; r.pass = pass; r.fail = fail;
        r.code = code; r.freg = freg; r.checks = k;
        return r;
    endfunction

    function automatic void add(input bit d, input bit rst, input logic v, input logic dup,
                                input logic we, input logic [4:0] rd, input logic [31:0] data,
                                input obs_t x);
        vec_t t;
        t.dut = d; t.rst = rst; t.v = v; t.dup = dup; t.we = we;
        t.rd = rd; t.data = data; t.exp = x; t.tag = section;
        tbl.push_back(t);
    endfunction

    function automatic void rstv(input bit d);
        add(d, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, Z);
    endfunction

    function automatic void org(input bit d, input logic we, input logic [4:0] rd,
                                input logic [31:0] data, input obs_t x);
        add(d, 1'b0, 1'b1, 1'b0, we, rd, data, x);
    endfunction

    function automatic void dupc(input bit d, input logic we, input logic [4:0] rd,
                                 input logic [31:0] data, input obs_t x);
        add(d, 1'b0, 1'b1, 1'b1, we, rd, data, x);
    endfunction

    function automatic void idle(input bit d, input int unsigned n, input obs_t x);
        for (int unsigned i = 0; i < n; i++) add(d, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, x);
    endfunction

    function automatic obs_t sample(input bit d);
        if (d) return e(bus_b.qed_ready, bus_b.qed_check_pass, bus_b.qed_check_fail,
                        bus_b.fail_code, bus_b.fail_reg, bus_b.checks_done);
        return e(bus_a.qed_ready, bus_a.qed_check_pass, bus_a.qed_check_fail,
                 bus_a.fail_code, bus_a.fail_reg, bus_a.checks_done);
    endfunction

    task automatic drive(input vec_t t);
        bus_a.commit_valid = 1'b0; bus_a.commit_dup = 1'b0; bus_a.commit_we = 1'b0;
        bus_a.commit_rd = '0; bus_a.commit_data = '0;
        bus_b.commit_valid = 1'b0; bus_b.commit_dup = 1'b0; bus_b.commit_we = 1'b0;
        bus_b.commit_rd = '0; bus_b.commit_data = '0;
        if (t.dut) begin
            bus_b.commit_valid = t.v; bus_b.commit_dup = t.dup; bus_b.commit_we = t.we;
            bus_b.commit_rd = t.rd; bus_b.commit_data = t.data;
            reset_b = ~t.rst;
        end else begin
            bus_a.commit_valid = t.v; bus_a.commit_dup = t.dup; bus_a.commit_we = t.we;
            bus_a.commit_rd = t.rd; bus_a.commit_data = t.data;
            reset_a = ~t.rst;
        end
    endtask

    task automatic check(input obs_t got, input obs_t want, input string tag, input int idx);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s[%0d]: got rdy=%0b pass=%0b fail=%0b code=%0d reg=%0d checks=%0d, want rdy=%0b pass=%0b fail=%0b code=%0d reg=%0d checks=%0d",
                     tag, idx, got.ready, got.pass, got.fail, got.code, got.freg, got.checks,
                     want.ready, want.pass, want.fail, want.code, want.freg, want.checks);
        end
    endtask

    function automatic void build();
        obs_t k1;
        k1 = e(0, 0, 0, 0, 0, 1);

        section = "clean";
        rstv(0);
        org(0, 1, 5'd3, 32'h1234, Z);
        dupc(0, 1, 5'd19, 32'h1234, Z);
        idle(0, 1, e(1, 0, 0, 0, 0, 0));
        idle(0, 14, Z);
        idle(0, 1, e(0, 1, 0, 0, 0, 1));
        idle(0, 3, k1);

        section = "abort";
        org(0, 1, 5'd1, 32'd7, k1);
        dupc(0, 1, 5'd17, 32'd7, k1);
        idle(0, 1, e(1, 0, 0, 0, 0, 1));
        idle(0, 2, k1);
        org(0, 1, 5'd2, 32'd9, k1);
        dupc(0, 1, 5'd18, 32'd9, k1);
        idle(0, 1, e(1, 0, 0, 0, 0, 1));
        idle(0, 14, k1);
        idle(0, 1, e(0, 1, 0, 0, 0, 2));
        idle(0, 1, e(0, 0, 0, 0, 0, 2));

        section = "mismatch";
        rstv(0);
        org(0, 1, 5'd5, 32'hA, Z);
        dupc(0, 1, 5'd21, 32'hB, Z);
        idle(0, 1, e(1, 0, 0, 0, 0, 0));
        idle(0, 4, Z);
        idle(0, 1, e(0, 0, 1, 0, 5, 0));
        dupc(0, 1, 5'd17, 32'd1, e(0, 0, 1, 0, 5, 0));
        org(0, 1, 5'd20, 32'd1, e(0, 0, 1, 0, 5, 0));
        idle(0, 2, e(0, 0, 1, 0, 5, 0));

        section = "pair15";
        rstv(0);
        org(0, 1, 5'd15, 32'd1, Z);
        dupc(0, 1, 5'd31, 32'd2, Z);
        idle(0, 1, e(1, 0, 0, 0, 0, 0));
        idle(0, 14, Z);
        idle(0, 1, e(0, 0, 1, 0, 15, 0));

        section = "order";
        rstv(0);
        dupc(0, 1, 5'd17, 32'd3, e(0, 0, 1, 1, 0, 0));
        org(0, 1, 5'd1, 32'd1, e(0, 0, 1, 1, 0, 0));

        section = "range_orig";
        rstv(0);
        org(0, 1, 5'd20, 32'd1, e(0, 0, 1, 2, 0, 0));

        section = "range_dup";
        rstv(0);
        org(0, 1, 5'd1, 32'd1, Z);
        dupc(0, 1, 5'd5, 32'd1, e(0, 0, 1, 2, 0, 0));

        section = "priority";
        rstv(0);
        dupc(0, 1, 5'd5, 32'd1, e(0, 0, 1, 1, 0, 0));

        section = "r0_nowrite";
        rstv(0);
        org(0, 1, 5'd0, 32'hFF, Z);
        dupc(0, 1, 5'd16, 32'd5, Z);
        org(0, 0, 5'd20, 32'd1, Z);
        dupc(0, 0, 5'd3, 32'd1, Z);
        idle(0, 1, e(1, 0, 0, 0, 0, 0));
        idle(0, 14, Z);
        idle(0, 1, e(0, 1, 0, 0, 0, 1));

        section = "reset_midsweep";
        rstv(0);
        org(0, 1, 5'd9, 32'd3, Z);
        dupc(0, 1, 5'd25, 32'd4, Z);
        idle(0, 1, e(1, 0, 0, 0, 0, 0));
        idle(0, 3, Z);
        rstv(0);
        idle(0, 2, Z);
        org(0, 1, 5'd8, 32'd5, Z);
        dupc(0, 1, 5'd24, 32'd5, Z);
        idle(0, 1, e(1, 0, 0, 0, 0, 0));
        idle(0, 14, Z);
        idle(0, 1, e(0, 1, 0, 0, 0, 1));

        section = "overflow";
        rstv(1);
        org(1, 1, 5'd1, 32'd1, Z);
        org(1, 1, 5'd2, 32'd2, Z);
        org(1, 1, 5'd3, 32'd3, Z);
        org(1, 1, 5'd4, 32'd4, e(0, 0, 1, 3, 0, 0));
        idle(1, 2, e(0, 0, 1, 3, 0, 0));
        rstv(1);
        org(1, 1, 5'd3, 32'h1234, Z);
        dupc(1, 1, 5'd19, 32'h1234, Z);
        idle(1, 1, e(1, 0, 0, 0, 0, 0));
        idle(1, 14, Z);
        idle(1, 1, e(0, 1, 0, 0, 0, 1));
    endfunction

    initial begin
        build();
        drive(tbl[0]);
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i]);
            sb.push_back(tbl[i].exp);
            if (tbl[i].rst) begin
                #1;
                check(sample(tbl[i].dut), Z, {tbl[i].tag, "_async_rst"}, i);
            end
            @(posedge clk);
            #1;
            check(sample(tbl[i].dut), sb.pop_front(), tbl[i].tag, i);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/qed_consistency_checker.md
# qed_consistency_checker

Commit-side partner of the QED instruction duplicator in the fetch stage. It watches the writeback commit stream, mirrors every register write into a shadow file, and tracks how many original and duplicate instructions have committed. Whenever the two streams are balanced it sweeps the register pairs (rN, rN+16) and reports pass or a sticky failure. It sits beside writeback and feeds the formal and simulation harness.

## Interface
Parameters:
- `DIFF_W`, default 8: width of the outstanding-originals counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `commit_valid` in 1: an instruction retires this cycle.
- `commit_dup` in 1: the retiring instruction is a QED duplicate (0 = original).
- `commit_we` in 1: the retiring instruction writes a register.
- `commit_rd` in 5: destination register.
- `commit_data` in 32: write-back value.
- `qed_ready` out 1: balanced state reached, sweep starting.
- `qed_check_pass` out 1: 1-cycle pulse, sweep found all pairs equal.
- `qed_check_fail` out 1: sticky failure flag.
- `fail_code` out 2: cause of failure. 0 = data mismatch, 1 = duplicate committed before its original, 2 = register-range violation, 3 = counter overflow.
- `fail_reg` out 4: pair index for a mismatch, otherwise 0.
- `checks_done` out 16: number of passing sweeps, wraps at 2^16.

## Operation
- **Shadow file.** 32×32 registers, all zero after reset.
  - A write commits when `commit_valid & commit_we` and `rd != 0`.
  - Writes to `rd == 0` are discarded.
- **Range rule.**
  - An original commit writing `rd >= 16` fails with code 2.
  - A duplicate commit writing `rd` in 1..15 fails with code 2.
- **Balance counter `diff`.** Counts originals minus duplicates; a `pending` flag is set by any commit.
  - Original commit: `diff + 1`. If `diff` is already 2^DIFF_W−1, fail with code 3.
  - Duplicate commit: `diff − 1`. If `diff` is 0, fail with code 1.
- **States.**
  - **TRACK** (reset state):
    - Go to CHECK when `diff == 0`, `pending == 1` and `commit_valid == 0`.
    - On entry: `qed_ready` pulses for 1 cycle, `pending` clears, pair index i = 1.
  - **CHECK:**
    - Each cycle compare `shadow[i]` with `shadow[i+16]`.
    - Mismatch: go to FAIL with code 0 and `fail_reg = i`.
    - After the i = 15 comparison matches: return to TRACK, pulse `qed_check_pass`, increment `checks_done`.
    - Any `commit_valid` during CHECK aborts to TRACK with no pass pulse. That commit is still applied to the shadow file and the counter.
  - **FAIL:** absorbing. All outputs hold, commits are ignored, and only reset leaves it.
- Pair 0 (r0 vs r16) is never compared.
- **Priority.** When one commit triggers several causes, record the lowest code among 1, 2, 3. Code 0 only comes from the sweep.

## Timing
- **Reset values.** `qed_ready`, `qed_check_pass`, `qed_check_fail`, `fail_code`, `fail_reg`, `checks_done` and `diff` all 0; `pending` 0; state TRACK; shadow file all zero.
- **Shadow writes** take effect at the clock edge; a compare one cycle later sees the new value.
- **Entering CHECK.** The entry condition is evaluated on registered state plus the current `commit_valid`. `qed_ready` is asserted in the first CHECK cycle.
- **Sweep latency.** 15 CHECK cycles. `qed_check_pass` is asserted in the cycle after the last compare, which is also the first TRACK cycle. Minimum period from balance to pass is 16 cycles.
- **Failure outputs.**
  - `qed_check_fail` rises in the cycle after the offending commit or compare and stays high.
  - `fail_code` and `fail_reg` are registered together with it and never change afterwards.
- **Reset mid-sweep** returns to TRACK and clears everything, including the shadow file.

## Structure
- Shared package `qed_pkg` holds:
  - fail-code constants;
  - state encoding (TRACK, CHECK, FAIL);
  - `QED_NUM_PAIRS = 16` and `QED_DUP_OFFSET = 16`.
- One sub-module, `qed_shadow_rf`: 32×32 register file with one write port and two combinational read ports (index i and i+16), async active-low reset, r0 write-suppressed.
- The FSM and counters stay in the top module.

## Test plan
- **Clean pass.** Original writes r3 = 0x1234, then duplicate writes r19 = 0x1234, then 16 idle cycles → `qed_ready` in the cycle after the duplicate, `qed_check_pass` 15 cycles later, `checks_done` = 1, fail stays 0.
- **Mismatch.** r5 = 0xA, r21 = 0xB, then idle → fail with code 0 and `fail_reg` = 5 on sweep cycle 5; outputs frozen afterwards.
- **Order violation.** First commit after reset is a duplicate writing r17 → fail with code 1 in the next cycle.
- **Range violation.** Original commit writes r20 → fail with code 2.
- **Abort and retry.** Balanced pair, then a commit on sweep cycle 3 → no pass pulse, returns to TRACK. Rebalance and idle → pass on the next sweep.
- **Overflow and reset.** With `DIFF_W` = 2, four originals with no duplicates → code 3 on the 4th. Assert `reset` for 1 cycle → all outputs back to 0, and a clean pass sequence then succeeds.
